// File: rtl/img2col_reader.sv
// -----------------------------------------------------------------------------
// img2col_reader
//
// Walks an IMG_W x IMG_H image held in a single-port RAM and emits it as a
// stream of KSIZE x KSIZE patches (img2col), one element per transfer.
// Windows step by STRIDE in x and y. Element order: oy (outer), ox, ky, kx.
// A 2-entry output FIFO absorbs the 1-cycle RAM latency, so reads are
// throttled to keep at most two elements queued or in flight.
//
// Ports
//   clka          clock, all logic on its rising edge
//   rst_n         asynchronous active-low reset
//   start         one-cycle request to process one tensor (ignored unless idle)
//   busy          high whenever the engine is not idle
//   done          one-cycle pulse after the last element has been accepted
//   ram_ena       RAM port enable (one read per asserted cycle)
//   ram_wea       RAM write enable, always 0
//   ram_addra     RAM read address
//   ram_douta     RAM read data, valid the cycle after ram_ena
//   out_data      patch element
//   out_valid     out_data valid
//   out_ready     consumer accepts; transfer on out_valid & out_ready
//   out_win_last  element is the last of its KSIZE x KSIZE window
//   out_last      element is the last of the whole tensor
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 10
`endif

module img2col_reader #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_SIZE  = `ADDR_SIZE,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int KSIZE      = 3,
    parameter int STRIDE     = 1
) (
    input  logic                  clka,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [ADDR_SIZE-1:0]  ram_addra,
    input  logic [DATA_WIDTH-1:0] ram_douta,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_win_last,
    output logic                  out_last
);

    localparam int OW = (IMG_W - KSIZE) / STRIDE + 1;
    localparam int OH = (IMG_H - KSIZE) / STRIDE + 1;
    localparam int CW = 16;

    localparam logic [CW-1:0] K_MAX  = CW'(KSIZE - 1);
    localparam logic [CW-1:0] OX_MAX = CW'(OW - 1);
    localparam logic [CW-1:0] OY_MAX = CW'(OH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state_reg, state_next;

    logic [CW-1:0] oy_reg, ox_reg, ky_reg, kx_reg;
    logic [CW-1:0] oy_next, ox_next, ky_next, kx_next;

    // One-stage tag pipeline that tracks the read currently in flight.
    logic pend_reg, pend_wl_reg, pend_l_reg;

    // 2-entry output FIFO.
    logic [DATA_WIDTH-1:0] fifo_data_reg [2];
    logic                  fifo_wl_reg   [2];
    logic                  fifo_l_reg    [2];
    logic                  wr_ptr_reg, rd_ptr_reg;
    logic [1:0]            count_reg;

    logic       pop;
    logic [1:0] occ;
    logic       issue;
    logic       win_end;
    logic       tensor_end;
    logic [ADDR_SIZE-1:0] addr_calc;

    assign pop = (count_reg != 2'd0) && out_ready;

    // Occupancy after this cycle's pop plus the read landing this cycle.
    // The issue rule keeps count_reg + pend_reg <= 2, so 2 bits suffice.
    assign occ   = count_reg + {1'b0, pend_reg} - {1'b0, pop};
    assign issue = (state_reg == RUN) && (occ < 2'd2);

    assign win_end    = (kx_reg == K_MAX) && (ky_reg == K_MAX);
    assign tensor_end = win_end && (ox_reg == OX_MAX) && (oy_reg == OY_MAX);

    // Arithmetic done directly at ADDR_SIZE width: identical to truncating
    // the full-precision address.
    assign addr_calc = (ADDR_SIZE'(oy_reg) * ADDR_SIZE'(STRIDE) + ADDR_SIZE'(ky_reg))
                       * ADDR_SIZE'(IMG_W)
                     + ADDR_SIZE'(ox_reg) * ADDR_SIZE'(STRIDE) + ADDR_SIZE'(kx_reg);

    assign ram_ena   = issue;
    assign ram_wea   = 1'b0;
    assign ram_addra = issue ? addr_calc : '0;

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);

    assign out_valid    = (count_reg != 2'd0);
    assign out_data     = out_valid ? fifo_data_reg[rd_ptr_reg] : '0;
    assign out_win_last = out_valid & fifo_wl_reg[rd_ptr_reg];
    assign out_last     = out_valid & fifo_l_reg[rd_ptr_reg];

    // Next-state and counter logic.
    always_comb begin
        state_next = state_reg;
        oy_next    = oy_reg;
        ox_next    = ox_reg;
        ky_next    = ky_reg;
        kx_next    = kx_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    oy_next    = '0;
                    ox_next    = '0;
                    ky_next    = '0;
                    kx_next    = '0;
                end
            end
            RUN: begin
                if (issue) begin
                    // Nested wrap: kx fastest, oy slowest. After the last
                    // element every counter has wrapped back to 0.
                    if (kx_reg == K_MAX) begin
                        kx_next = '0;
                        if (ky_reg == K_MAX) begin
                            ky_next = '0;
                            if (ox_reg == OX_MAX) begin
                                ox_next = '0;
                                oy_next = (oy_reg == OY_MAX) ? '0 : oy_reg + 1'b1;
                            end else begin
                                ox_next = ox_reg + 1'b1;
                            end
                        end else begin
                            ky_next = ky_reg + 1'b1;
                        end
                    end else begin
                        kx_next = kx_reg + 1'b1;
                    end
                    if (tensor_end) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave once the final transfer happens this cycle (or
                // already happened) and nothing remains in flight.
                if (!pend_reg && (occ == 2'd0)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            oy_reg    <= '0;
            ox_reg    <= '0;
            ky_reg    <= '0;
            kx_reg    <= '0;
        end else begin
            state_reg <= state_next;
            oy_reg    <= oy_next;
            ox_reg    <= ox_next;
            ky_reg    <= ky_next;
            kx_reg    <= kx_next;
        end
    end

    // Read tags and output FIFO. Window/tensor flags are captured at issue
    // time and travel with the data.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg    <= 1'b0;
            pend_wl_reg <= 1'b0;
            pend_l_reg  <= 1'b0;
            wr_ptr_reg  <= 1'b0;
            rd_ptr_reg  <= 1'b0;
            count_reg   <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_reg[i] <= '0;
                fifo_wl_reg[i]   <= 1'b0;
                fifo_l_reg[i]    <= 1'b0;
            end
        end else begin
            pend_reg    <= issue;
            pend_wl_reg <= issue & win_end;
            pend_l_reg  <= issue & tensor_end;
            if (pend_reg) begin
                fifo_data_reg[wr_ptr_reg] <= ram_douta;
                fifo_wl_reg[wr_ptr_reg]   <= pend_wl_reg;
                fifo_l_reg[wr_ptr_reg]    <= pend_l_reg;
                wr_ptr_reg                <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= occ;
        end
    end

endmodule

// File: tb/tb_img2col_reader.sv
// -----------------------------------------------------------------------------
// tb_img2col_reader
//
// Two instances: A (4x4 image, K=3, S=1) and B (5x5 image, K=3, S=2), each
// with a RAM model returning mem[i]=i one cycle after ram_ena. Expected
// elements are pushed to a per-instance queue when start is driven and popped
// on every out_valid & out_ready transfer.
// -----------------------------------------------------------------------------
module tb_img2col_reader;

    localparam int DW = 8;
    localparam int AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] start_v;
    logic [1:0] ready_v;

    logic          a_busy, a_done, a_ena, a_wea, a_valid, a_wl, a_l;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_douta, a_data;
    logic          b_busy, b_done, b_ena, b_wea, b_valid, b_wl, b_l;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_douta, b_data;

    img2col_reader #(.DATA_WIDTH(DW), .ADDR_SIZE(AW), .IMG_W(4), .IMG_H(4),
                     .KSIZE(3), .STRIDE(1)) dut_a (
        .clka(clk), .rst_n(rst_n), .start(start_v[0]), .busy(a_busy), .done(a_done),
        .ram_ena(a_ena), .ram_wea(a_wea), .ram_addra(a_addr), .ram_douta(a_douta),
        .out_data(a_data), .out_valid(a_valid), .out_ready(ready_v[0]),
        .out_win_last(a_wl), .out_last(a_l)
    );

    img2col_reader #(.DATA_WIDTH(DW), .ADDR_SIZE(AW), .IMG_W(5), .IMG_H(5),
                     .KSIZE(3), .STRIDE(2)) dut_b (
        .clka(clk), .rst_n(rst_n), .start(start_v[1]), .busy(b_busy), .done(b_done),
        .ram_ena(b_ena), .ram_wea(b_wea), .ram_addra(b_addr), .ram_douta(b_douta),
        .out_data(b_data), .out_valid(b_valid), .out_ready(ready_v[1]),
        .out_win_last(b_wl), .out_last(b_l)
    );

    // RAM models: mem[i] = i, one-cycle read latency.
    always @(posedge clk) begin
        if (a_ena) a_douta <= a_addr;
        if (b_ena) b_douta <= b_addr;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected element: [9:2] data, [1] win_last, [0] last.
    logic [9:0] qa[$];
    logic [9:0] qb[$];

    int n_cmp = 0;
    int n_bad = 0;

    int reads[2], xfers[2], done_cnt[2], start_cyc[2];
    int first_ena[2], last_ena[2], first_valid[2], last_valid[2], done_rel[2];
    int ready_mode[2];   // 0 = hold low, 1 = hold high, 2 = toggle

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_expected(input int i, input int w, input int h, input int k, input int s);
        int ow, oh, addr;
        logic wl, l;
        ow = (w - k) / s + 1;
        oh = (h - k) / s + 1;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int ky = 0; ky < k; ky++)
                    for (int kx = 0; kx < k; kx++) begin
                        addr = (oy * s + ky) * w + ox * s + kx;
                        wl = (ky == k - 1) && (kx == k - 1);
                        l  = wl && (ox == ow - 1) && (oy == oh - 1);
                        if (i == 0) qa.push_back({8'(addr), wl, l});
                        else        qb.push_back({8'(addr), wl, l});
                    end
    endtask

    task automatic clear_stats(input int i);
        reads[i] = 0; xfers[i] = 0; done_cnt[i] = 0;
        first_ena[i] = -1; last_ena[i] = -1; first_valid[i] = -1;
        last_valid[i] = -1; done_rel[i] = -1;
    endtask

    // Per-cycle monitor for one instance.
    task automatic mon_step(input int i);
        logic       ena, valid, rdy, dn, wl, l;
        logic [7:0] data;
        logic [9:0] front, e;
        bit         have;
        int         rel;
        ena   = (i == 0) ? a_ena   : b_ena;
        valid = (i == 0) ? a_valid : b_valid;
        dn    = (i == 0) ? a_done  : b_done;
        wl    = (i == 0) ? a_wl    : b_wl;
        l     = (i == 0) ? a_l     : b_l;
        data  = (i == 0) ? a_data  : b_data;
        rdy   = ready_v[i];
        rel   = cyc - start_cyc[i];
        have  = (i == 0) ? (qa.size() > 0) : (qb.size() > 0);
        front = have ? ((i == 0) ? qa[0] : qb[0]) : 10'd0;

        if (ena) begin
            reads[i]++;
            if (first_ena[i] < 0) first_ena[i] = rel;
            last_ena[i] = rel;
        end
        if (valid) begin
            if (first_valid[i] < 0) first_valid[i] = rel;
            last_valid[i] = rel;
        end
        if (dn) begin
            done_cnt[i]++;
            done_rel[i] = rel;
        end
        if (valid && rdy) begin
            xfers[i]++;
            if (!have) begin
                check_val("spurious_xfer", 32'(data), 32'hFFFF);
            end else begin
                e = (i == 0) ? qa.pop_front() : qb.pop_front();
                $display("dut%0d xfer %0d: data=%0d win_last=%0b last=%0b", i, xfers[i], data, wl, l);
                check_val("data",     32'(data), 32'(e[9:2]));
                check_val("win_last", 32'(wl),   32'(e[1]));
                check_val("last",     32'(l),    32'(e[0]));
            end
        end else if (valid && have) begin
            check_val("stall_data", 32'(data), 32'(front[9:2]));
        end
        check_val("read_ahead", 32'((reads[i] - xfers[i]) <= 2), 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) mon_step(i);
        end
    end

    // Ready toggler for mode 2.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++)
                if (ready_mode[i] == 2) ready_v[i] = ~ready_v[i];
        end
    end

    task automatic start_tensor(input int i, input int w, input int h, input int k, input int s);
        push_expected(i, w, h, k, s);
        clear_stats(i);
        @(posedge clk); #1;
        start_v[i]   = 1'b1;
        start_cyc[i] = cyc;
        @(posedge clk); #1;
        start_v[i]   = 1'b0;
    endtask

    task automatic wait_done(input int i, input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt[i] < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_val("done_seen", 32'(done_cnt[i] >= target), 32'd1);
    endtask

    // Full tensor on A with ready held high, including latency checks.
    task automatic run_basic();
        ready_mode[0] = 1;
        ready_v[0]    = 1'b1;
        start_tensor(0, 4, 4, 3, 1);
        wait_done(0, 1, 200);
        check_val("first_ena",   32'(first_ena[0]),   32'd1);
        check_val("last_ena",    32'(last_ena[0]),    32'd36);
        check_val("first_valid", 32'(first_valid[0]), 32'd3);
        check_val("last_valid",  32'(last_valid[0]),  32'd38);
        check_val("done_cycle",  32'(done_rel[0]),    32'd39);
        check_val("xfer_count",  32'(xfers[0]),       32'd36);
        check_val("read_count",  32'(reads[0]),       32'd36);
        check_val("queue_empty", 32'(qa.size()),      32'd0);
        @(posedge clk); #1;
        check_val("idle_busy",   32'(a_busy),         32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        start_v = 2'b00;
        ready_v = 2'b00;
        ready_mode[0] = 0;
        ready_mode[1] = 0;
        clear_stats(0);
        clear_stats(1);
        start_cyc[0] = 0;
        start_cyc[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy",  32'(a_busy),  32'd0);
        check_val("rst_done",  32'(a_done),  32'd0);
        check_val("rst_ena",   32'(a_ena),   32'd0);
        check_val("rst_valid", 32'(a_valid), 32'd0);
        check_val("rst_addr",  32'(a_addr),  32'd0);
        check_val("rst_wea",   32'(a_wea),   32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Ready held high: timing and full sequence.
        run_basic();

        // Ready toggling 1010...
        ready_mode[0] = 2;
        ready_v[0]    = 1'b1;
        start_tensor(0, 4, 4, 3, 1);
        wait_done(0, 1, 400);
        check_val("toggle_xfers", 32'(xfers[0]),  32'd36);
        check_val("toggle_queue", 32'(qa.size()), 32'd0);
        ready_mode[0] = 0;

        // Consumer stalled for 20 cycles.
        ready_v[0] = 1'b0;
        start_tensor(0, 4, 4, 3, 1);
        repeat (19) @(posedge clk);
        #1;
        check_val("stall_valid",       32'(a_valid),        32'd1);
        check_val("stall_head",        32'(a_data),         32'd0);
        check_val("stall_reads",       32'(reads[0]),       32'd2);
        check_val("stall_first_valid", 32'(first_valid[0]), 32'd3);
        ready_v[0] = 1'b1;
        wait_done(0, 1, 200);
        check_val("stall_xfers", 32'(xfers[0]),  32'd36);
        check_val("stall_queue", 32'(qa.size()), 32'd0);

        // Reset in the middle of a tensor.
        ready_v[0] = 1'b1;
        start_tensor(0, 4, 4, 3, 1);
        n = 0;
        while (xfers[0] < 10 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check_val("mid_reached", 32'(xfers[0] >= 10), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("midrst_busy",  32'(a_busy),  32'd0);
        check_val("midrst_done",  32'(a_done),  32'd0);
        check_val("midrst_ena",   32'(a_ena),   32'd0);
        check_val("midrst_valid", 32'(a_valid), 32'd0);
        check_val("midrst_data",  32'(a_data),  32'd0);
        check_val("midrst_wl",    32'(a_wl),    32'd0);
        check_val("midrst_last",  32'(a_l),     32'd0);
        check_val("midrst_addr",  32'(a_addr),  32'd0);
        qa.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_val("midrst_no_done", 32'(done_cnt[0]), 32'd0);
        run_basic();

        // start reasserted while busy.
        start_tensor(0, 4, 4, 3, 1);
        repeat (5) @(posedge clk);
        #1; start_v[0] = 1'b1;
        @(posedge clk); #1; start_v[0] = 1'b0;
        repeat (15) @(posedge clk);
        #1; start_v[0] = 1'b1;
        @(posedge clk); #1; start_v[0] = 1'b0;
        wait_done(0, 1, 200);
        repeat (10) @(posedge clk);
        #1;
        check_val("restart_done_cnt", 32'(done_cnt[0]), 32'd1);
        check_val("restart_xfers",    32'(xfers[0]),    32'd36);
        check_val("restart_queue",    32'(qa.size()),   32'd0);
        check_val("restart_busy",     32'(a_busy),      32'd0);

        // Instance B: 5x5, stride 2.
        ready_mode[1] = 1;
        ready_v[1]    = 1'b1;
        start_tensor(1, 5, 5, 3, 2);
        wait_done(1, 1, 200);
        check_val("b_xfers",      32'(xfers[1]),       32'd36);
        check_val("b_queue",      32'(qb.size()),      32'd0);
        check_val("b_first_ena",  32'(first_ena[1]),   32'd1);
        check_val("b_done_cycle", 32'(done_rel[1]),    32'd39);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/img2col_reader.md
IMG2COL_READER -- requirements
Module: img2col_reader

Interface
REQ-001 Parameter DATA_WIDTH, default `DATA_WIDTH, RAM word and output width.
REQ-002 Parameter ADDR_SIZE, default `ADDR_SIZE, RAM address width.
REQ-003 Parameter IMG_W, default 8, input image width in pixels.
REQ-004 Parameter IMG_H, default 8, input image height in pixels.
REQ-005 Parameter KSIZE, default 3, square kernel edge length.
REQ-006 Parameter STRIDE, default 1, window step in x and y.
REQ-007 clka  in  1  single clock; all logic on its rising edge.
REQ-008 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-009 start  in  1  one-cycle request to process one tensor.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse when the tensor is complete.
REQ-012 ram_ena  out  1  RAM port enable.
REQ-013 ram_wea  out  1  RAM write enable; tied 0.
REQ-014 ram_addra  out  ADDR_SIZE  RAM read address.
REQ-015 ram_douta  in  DATA_WIDTH  RAM read data, valid the cycle after ram_ena.
REQ-016 out_data  out  DATA_WIDTH  patch element.
REQ-017 out_valid  out  1  out_data valid.
REQ-018 out_ready  in  1  consumer accepts; transfer when out_valid & out_ready.
REQ-019 out_win_last  out  1  current element is the last of its KSIZE x KSIZE window.
REQ-020 out_last  out  1  current element is the last of the whole tensor.

Function
REQ-021 OW=(IMG_W-KSIZE)/STRIDE+1, OH=(IMG_H-KSIZE)/STRIDE+1, total elements N=OW*OH*KSIZE*KSIZE.
REQ-022 Read order: oy outer, ox, ky, kx inner; address=(oy*STRIDE+ky)*IMG_W+(ox*STRIDE+kx), truncated to ADDR_SIZE.
REQ-023 FSM states IDLE, RUN, DRAIN, DONE.
REQ-024 IDLE->RUN on start; counters oy,ox,ky,kx cleared to 0.
REQ-025 RUN: issue a read (ram_ena=1) only when FIFO occupancy + in-flight reads (after this cycle's pop) < 2; counters advance only on an issued read.
REQ-026 RUN->DRAIN in the cycle the read for element N-1 is issued.
REQ-027 DRAIN->DONE when no read is in flight and the FIFO is empty (final transfer completed).
REQ-028 DONE: done=1 for exactly one cycle, then IDLE.
REQ-029 start is ignored outside IDLE.
REQ-030 ram_douta captured into a 2-entry output FIFO the cycle after the read; FIFO never overflows, never drops data.
REQ-031 out_valid=FIFO non-empty; out_data, out_win_last, out_last come from the FIFO head and stay stable while out_valid & !out_ready.
REQ-032 out_win_last and out_last are computed at issue time and carried with the data.
REQ-033 Latency: start sampled in cycle C0 -> first ram_ena in C1 -> out_valid in C3.
REQ-034 With out_ready held high, one transfer per cycle; N transfers in N consecutive cycles.
REQ-035 ram_ena=0 in IDLE, DRAIN and DONE.

Reset
REQ-036 rst_n low: state=IDLE, counters=0, FIFO empty, in-flight cleared; busy, done, ram_ena, out_valid, out_win_last, out_last = 0; ram_addra = 0.
REQ-037 Reset mid-operation abandons the tensor; no done pulse; next start begins at element 0.

Verification (RAM model mem[i]=i, 1-cycle read latency)
REQ-038 IMG_W=IMG_H=4, KSIZE=3, STRIDE=1, out_ready=1, start in C0 -> ram_ena C1..C36, out_valid C3..C38, first window data 0,1,2,4,5,6,8,9,10 with out_win_last on 10, second window starts with 1, out_last on the 36th element (15), done pulse in C39.
REQ-039 Same config, out_ready toggled 1010... -> identical 36-element sequence, at most 2 reads ahead of the consumer, no loss or duplication.
REQ-040 out_ready=0 for 20 cycles after start -> out_valid high from C3, out_data stays 0, exactly 2 reads issued, then stream resumes at 1 when ready rises.
REQ-041 IMG_W=IMG_H=5, KSIZE=3, STRIDE=2 -> 36 elements, second window begins at address 2, last element 24 with out_last=1.
REQ-042 rst_n pulled low at element 10 -> all outputs 0 next cycle, no done; fresh start reproduces the REQ-038 sequence from 0.
REQ-043 start reasserted while busy -> ignored; exactly one done per accepted start.
